// File: rtl/div_sequencer.sv
// div_sequencer
//   Controller for the M-extension iterative unsigned divide core. Accepts
//   DIV/DIVU/REM/REMU requests, converts signed operands to magnitudes, runs
//   the core once, sign-corrects the quotient or remainder and returns it
//   over a valid/ready handshake. Divide-by-zero and signed overflow are
//   resolved locally without starting the core.
//
//   Optional feature macro: DIV_RESULT_CACHE_EN
//     When defined, a one-entry result cache lets a repeated operand pair
//     with the same signedness bypass the core (e.g. DIV followed by REM).
//
//   Ports
//     i_clk, i_rst           clock, synchronous active-high reset
//     i_valid / o_ready      request handshake
//     i_op                   00 DIV, 01 DIVU, 10 REM, 11 REMU
//     i_rs1, i_rs2           dividend, divisor
//     i_flush                abort any operation in flight
//     o_valid / i_ready      result handshake, o_result held until taken
//     o_result               quotient or remainder
//     o_core_start           one-cycle start pulse to the divide core
//     o_core_a, o_core_b     unsigned magnitudes fed to the core
//     i_core_res, i_core_rem core quotient / remainder
//     i_core_done            one-cycle pulse, core outputs valid
module div_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic        i_flush,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_core_start,
    output logic [31:0] o_core_a,
    output logic [31:0] o_core_b,
    input  logic [31:0] i_core_res,
    input  logic [31:0] i_core_rem,
    input  logic        i_core_done
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t            r_state;
    logic              r_ready;
    logic              r_valid;
    logic              r_core_start;
    logic [XLEN-1:0]   r_result;
    logic [XLEN-1:0]   r_core_a;
    logic [XLEN-1:0]   r_core_b;
    logic              r_rem_sel;
    logic              r_negq;
    logic              r_negr;

    // Request decode
    logic              w_signed;
    logic              w_rem_sel;
    logic              w_div0;
    logic              w_ovf;
    logic [XLEN-1:0]   w_mag_a;
    logic [XLEN-1:0]   w_mag_b;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;
    logic              w_hit;
    logic [XLEN-1:0]   w_hit_res;

    assign w_signed  = ~i_op[0];
    assign w_rem_sel = i_op[1];
    assign w_div0    = (i_rs2 == '0);
    assign w_ovf     = w_signed && (i_rs1 == {1'b1, {(XLEN-1){1'b0}}})
                                && (i_rs2 == {XLEN{1'b1}});

    // Two's-complement negate; 0x80000000 maps onto itself, which is the
    // correct unsigned magnitude of the most negative value.
    assign w_mag_a = (w_signed && i_rs1[XLEN-1]) ? (~i_rs1 + XLEN'(1)) : i_rs1;
    assign w_mag_b = (w_signed && i_rs2[XLEN-1]) ? (~i_rs2 + XLEN'(1)) : i_rs2;

    // Sign correction of core outputs
    assign w_q_fix = r_negq ? (~i_core_res + XLEN'(1)) : i_core_res;
    assign w_r_fix = r_negr ? (~i_core_rem + XLEN'(1)) : i_core_rem;

`ifdef DIV_RESULT_CACHE_EN
    logic              r_signed;
    logic [XLEN-1:0]   r_rs1;
    logic [XLEN-1:0]   r_rs2;
    logic              r_c_valid;
    logic [XLEN-1:0]   r_c_rs1;
    logic [XLEN-1:0]   r_c_rs2;
    logic              r_c_signed;
    logic [XLEN-1:0]   r_c_quo;
    logic [XLEN-1:0]   r_c_rem;

    assign w_hit     = r_c_valid && (r_c_rs1 == i_rs1) && (r_c_rs2 == i_rs2)
                                 && (r_c_signed == w_signed);
    assign w_hit_res = w_rem_sel ? r_c_rem : r_c_quo;

    // Cache entry: written on every core completion, cleared only by reset
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_signed   <= 1'b0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_c_valid  <= 1'b0;
            r_c_rs1    <= '0;
            r_c_rs2    <= '0;
            r_c_signed <= 1'b0;
            r_c_quo    <= '0;
            r_c_rem    <= '0;
        end else begin
            if (r_state == S_IDLE && i_valid && !i_flush) begin
                r_signed <= w_signed;
                r_rs1    <= i_rs1;
                r_rs2    <= i_rs2;
            end
            if (r_state == S_WAIT && i_core_done && !i_flush) begin
                r_c_valid  <= 1'b1;
                r_c_rs1    <= r_rs1;
                r_c_rs2    <= r_rs2;
                r_c_signed <= r_signed;
                r_c_quo    <= w_q_fix;
                r_c_rem    <= w_r_fix;
            end
        end
    end
`else
    assign w_hit     = 1'b0;
    assign w_hit_res = '0;
`endif

    // Sequencer FSM with registered outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_ready      <= 1'b1;
            r_valid      <= 1'b0;
            r_core_start <= 1'b0;
            r_result     <= '0;
            r_core_a     <= '0;
            r_core_b     <= '0;
            r_rem_sel    <= 1'b0;
            r_negq       <= 1'b0;
            r_negr       <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            if (i_flush) begin
                // Abort wins over everything, including a same-cycle request
                r_state <= S_IDLE;
                r_ready <= 1'b1;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_valid) begin
                            r_rem_sel <= w_rem_sel;
                            r_negq    <= w_signed && (i_rs1[XLEN-1] ^ i_rs2[XLEN-1]);
                            r_negr    <= w_signed && i_rs1[XLEN-1];
                            r_ready   <= 1'b0;
                            if (w_div0) begin
                                r_result <= w_rem_sel ? i_rs1 : {XLEN{1'b1}};
                                r_valid  <= 1'b1;
                                r_state  <= S_RESP;
                            end else if (w_ovf) begin
                                r_result <= w_rem_sel ? '0 : {1'b1, {(XLEN-1){1'b0}}};
                                r_valid  <= 1'b1;
                                r_state  <= S_RESP;
                            end else if (w_hit) begin
                                r_result <= w_hit_res;
                                r_valid  <= 1'b1;
                                r_state  <= S_RESP;
                            end else begin
                                r_core_a     <= w_mag_a;
                                r_core_b     <= w_mag_b;
                                r_core_start <= 1'b1;
                                r_state      <= S_START;
                            end
                        end
                    end
                    S_START: begin
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (i_core_done) begin
                            r_result <= r_rem_sel ? w_r_fix : w_q_fix;
                            r_valid  <= 1'b1;
                            r_state  <= S_RESP;
                        end
                    end
                    S_RESP: begin
                        if (i_ready) begin
                            r_valid <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_ready <= 1'b1;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_ready      = r_ready;
    assign o_valid      = r_valid;
    assign o_core_start = r_core_start;
    assign o_result     = r_result;
    assign o_core_a     = r_core_a;
    assign o_core_b     = r_core_b;

endmodule

// File: tb/tb_div_sequencer.sv
// tb_div_sequencer
//   Directed bench for div_sequencer. The bench plays the role of the divide
//   core by hand: it drives i_core_done with precomputed quotient/remainder
//   values. Inputs change and outputs are sampled on the falling clock edge.
module tb_div_sequencer;

    logic        i_clk;
    logic        i_rst;
    logic        i_valid;
    logic        o_ready;
    logic [1:0]  i_op;
    logic [31:0] i_rs1;
    logic [31:0] i_rs2;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_result;
    logic        o_core_start;
    logic [31:0] o_core_a;
    logic [31:0] o_core_b;
    logic [31:0] i_core_res;
    logic [31:0] i_core_rem;
    logic        i_core_done;

    int n_chk;
    int n_err;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    div_sequencer dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_op         (i_op),
        .i_rs1        (i_rs1),
        .i_rs2        (i_rs2),
        .i_flush      (i_flush),
        .o_valid      (o_valid),
        .i_ready      (i_ready),
        .o_result     (o_result),
        .o_core_start (o_core_start),
        .o_core_a     (o_core_a),
        .o_core_b     (o_core_b),
        .i_core_res   (i_core_res),
        .i_core_rem   (i_core_rem),
        .i_core_done  (i_core_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ":ready"},  32'(o_ready),      32'd1);
        chk({tag, ":valid"},  32'(o_valid),      32'd0);
        chk({tag, ":start"},  32'(o_core_start), 32'd0);
        chk({tag, ":result"}, o_result,          32'd0);
        chk({tag, ":core_a"}, o_core_a,          32'd0);
        chk({tag, ":core_b"}, o_core_b,          32'd0);
    endtask

    // Present a request for one cycle; returns on the falling edge after accept
    task automatic issue(input string tag, input logic [1:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        i_valid = 1'b1;
        i_op    = op;
        i_rs1   = a;
        i_rs2   = b;
        chk({tag, ":ready_before"}, 32'(o_ready), 32'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    // Consume the result and confirm return to IDLE
    task automatic take(input string tag, input logic [31:0] exp);
        chk({tag, ":valid"},  32'(o_valid), 32'd1);
        chk({tag, ":result"}, o_result,     exp);
        i_ready = 1'b1;
        @(negedge i_clk);
        i_ready = 1'b0;
        chk({tag, ":valid_after"}, 32'(o_valid), 32'd0);
        chk({tag, ":ready_after"}, 32'(o_ready), 32'd1);
    endtask

    // Request resolved without the core: result visible the cycle after accept
    task automatic run_fast(input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp);
        issue(tag, op, a, b);
        chk({tag, ":no_start"}, 32'(o_core_start), 32'd0);
        take(tag, exp);
    endtask

    // Request that runs the core; bench supplies the core response
    task automatic run_norm(input string tag, input logic [1:0] op,
                            input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] ma, input logic [31:0] mb,
                            input logic [31:0] cres, input logic [31:0] crem,
                            input logic [31:0] exp);
        issue(tag, op, a, b);
        chk({tag, ":start"},  32'(o_core_start), 32'd1);
        chk({tag, ":core_a"}, o_core_a, ma);
        chk({tag, ":core_b"}, o_core_b, mb);
        @(negedge i_clk);
        chk({tag, ":start_pulse"}, 32'(o_core_start), 32'd0);
        chk({tag, ":wait_valid"},  32'(o_valid), 32'd0);
        i_core_done = 1'b1;
        i_core_res  = cres;
        i_core_rem  = crem;
        @(negedge i_clk);
        i_core_done = 1'b0;
        take(tag, exp);
    endtask

    initial begin
        n_chk       = 0;
        n_err       = 0;
        i_rst       = 1'b1;
        i_valid     = 1'b0;
        i_op        = 2'b00;
        i_rs1       = '0;
        i_rs2       = '0;
        i_flush     = 1'b0;
        i_ready     = 1'b0;
        i_core_res  = '0;
        i_core_rem  = '0;
        i_core_done = 1'b0;

        // Reset
        repeat (2) @(negedge i_clk);
        chk_reset_values("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // Signed and unsigned arithmetic through the core
        run_norm("div_m7_2", OP_DIV, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2,
                 32'd3, 32'd1, 32'hFFFF_FFFD);
`ifdef DIV_RESULT_CACHE_EN
        run_fast("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
`else
        run_norm("rem_m7_2", OP_REM, 32'hFFFF_FFF9, 32'd2, 32'd7, 32'd2,
                 32'd3, 32'd1, 32'hFFFF_FFFF);
`endif
        run_norm("divu_big", OP_DIVU, 32'hFFFF_FFFF, 32'h10, 32'hFFFF_FFFF, 32'h10,
                 32'h0FFF_FFFF, 32'hF, 32'h0FFF_FFFF);
`ifdef DIV_RESULT_CACHE_EN
        run_fast("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hF);
`else
        run_norm("remu_big", OP_REMU, 32'hFFFF_FFFF, 32'h10, 32'hFFFF_FFFF, 32'h10,
                 32'h0FFF_FFFF, 32'hF, 32'hF);
`endif
        // Most negative dividend keeps 0x80000000 as its magnitude
        run_norm("div_min_2", OP_DIV, 32'h8000_0000, 32'd2, 32'h8000_0000, 32'd2,
                 32'h4000_0000, 32'd0, 32'hC000_0000);
        // Negative divisor, positive dividend: remainder keeps dividend sign
        run_norm("rem_7_m2", OP_REM, 32'd7, 32'hFFFF_FFFE, 32'd7, 32'd2,
                 32'd3, 32'd1, 32'd1);

        // Divide-by-zero and signed overflow
        run_fast("div_by0",  OP_DIV,  32'd5, 32'd0, 32'hFFFF_FFFF);
        run_fast("rem_by0",  OP_REM,  32'd5, 32'd0, 32'd5);
        run_fast("divu_by0", OP_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_fast("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_fast("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0);

        // Backpressure: result held, new request not accepted
        issue("bp", OP_DIV, 32'd5, 32'd0);
        i_valid = 1'b1;
        i_op    = OP_DIVU;
        i_rs1   = 32'd9;
        i_rs2   = 32'd3;
        for (int k = 0; k < 10; k++) begin
            chk("bp:valid_held",  32'(o_valid),      32'd1);
            chk("bp:result_held", o_result,          32'hFFFF_FFFF);
            chk("bp:ready_low",   32'(o_ready),      32'd0);
            chk("bp:no_start",    32'(o_core_start), 32'd0);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        take("bp", 32'hFFFF_FFFF);
        @(negedge i_clk);
        chk("bp:idle_valid", 32'(o_valid),      32'd0);
        chk("bp:idle_start", 32'(o_core_start), 32'd0);

        // Flush beats a same-cycle request
        i_valid = 1'b1;
        i_flush = 1'b1;
        i_op    = OP_DIV;
        i_rs1   = 32'd5;
        i_rs2   = 32'd0;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush_acc:valid", 32'(o_valid), 32'd0);
        chk("flush_acc:ready", 32'(o_ready), 32'd1);

        // Flush in WAIT, stale core completions ignored
        issue("flw", OP_DIV, 32'd200, 32'd9);
        chk("flw:start", 32'(o_core_start), 32'd1);
        @(negedge i_clk);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        chk("flw:valid", 32'(o_valid), 32'd0);
        chk("flw:ready", 32'(o_ready), 32'd1);
        i_core_done = 1'b1;
        i_core_res  = 32'd22;
        i_core_rem  = 32'd2;
        @(negedge i_clk);
        i_core_done = 1'b0;
        chk("flw:stale_idle", 32'(o_valid), 32'd0);
        issue("flw_new", OP_DIVU, 32'd100, 32'd7);
        chk("flw_new:start",  32'(o_core_start), 32'd1);
        chk("flw_new:core_a", o_core_a, 32'd100);
        chk("flw_new:core_b", o_core_b, 32'd7);
        // Late completion of the aborted run lands in START and must be dropped
        i_core_done = 1'b1;
        @(negedge i_clk);
        i_core_done = 1'b0;
        chk("flw_new:stale_start", 32'(o_valid), 32'd0);
        i_core_done = 1'b1;
        i_core_res  = 32'd14;
        i_core_rem  = 32'd2;
        @(negedge i_clk);
        i_core_done = 1'b0;
        take("flw_new", 32'd14);

        // Reset while waiting on the core
        issue("rstw", OP_DIVU, 32'd9, 32'd3);
        chk("rstw:start", 32'(o_core_start), 32'd1);
        @(negedge i_clk);
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk_reset_values("rstw");
        @(negedge i_clk);

        // Operand reuse across DIV / REM / REMU
        run_norm("div_100_7", OP_DIV, 32'd100, 32'd7, 32'd100, 32'd7,
                 32'd14, 32'd2, 32'd14);
`ifdef DIV_RESULT_CACHE_EN
        run_fast("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd2);
`else
        run_norm("rem_100_7", OP_REM, 32'd100, 32'd7, 32'd100, 32'd7,
                 32'd14, 32'd2, 32'd2);
`endif
        run_norm("remu_100_7", OP_REMU, 32'd100, 32'd7, 32'd100, 32'd7,
                 32'd14, 32'd2, 32'd2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Controller for the M-extension iterative unsigned divide core: accepts DIV/DIVU/REM/REMU requests from the execute stage, converts signed operands to magnitudes, sequences one core run, sign-corrects the quotient or remainder, and returns it over a valid/ready handshake. Divide-by-zero and signed overflow are resolved without starting the core. Sits between the EX-stage M-unit mux and the divide core instance.

## Interface
- No parameters; datapath fixed at 32 bits.
- i_clk  in  1  clock; all logic rising-edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  request valid.
- o_ready  out  1  request accepted when i_valid && o_ready.
- i_op  in  2  00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- i_rs1, i_rs2  in  32  dividend, divisor.
- i_flush  in  1  abort current operation.
- o_valid  out  1  result valid, held until taken.
- i_ready  in  1  consumer accepts result when o_valid && i_ready.
- o_result  out  32  quotient or remainder per latched op.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_a, o_core_b  out  32  unsigned dividend/divisor magnitudes.
- i_core_res, i_core_rem  in  32  core quotient/remainder.
- i_core_done  in  1  one-cycle pulse: core outputs valid.

## Operation
- States: IDLE, START, WAIT, RESP.
- IDLE: o_ready=1. On accept, latch op, signed flag (~i_op[0]), rem-select (i_op[1]), negq = signed & (rs1[31]^rs2[31]), negr = signed & rs1[31].
  - rs2==0: result = rem-select ? rs1 : 0xFFFFFFFF; go to RESP.
  - signed & rs1==0x80000000 & rs2==0xFFFFFFFF: result = rem-select ? 0 : 0x80000000; go to RESP.
  - Else latch magnitudes (two's-complement negate if signed and MSB set; 0x80000000 stays 0x80000000 unsigned); go to START.
- START: o_core_start=1 for exactly one cycle; go to WAIT.
- WAIT: on i_core_done, result = rem-select ? (negr ? -rem : rem) : (negq ? -res : res); go to RESP.
- RESP: o_valid=1, o_result stable; on i_ready go to IDLE.
- i_core_done outside WAIT is ignored.
- i_flush (any state): next state IDLE, o_valid=0, no result produced. The core must treat a new o_core_start as abandoning any prior run; a stale i_core_done after flush is ignored.
- i_flush has priority over acceptance in the same cycle: no request accepted.

## Timing
- Reset values: o_ready=1 (state IDLE), o_valid=0, o_core_start=0, o_result=0, o_core_a=0, o_core_b=0.
- Accept at cycle T. Special case: o_valid at T+1.
- Normal: o_core_start at T+1; core done sampled at cycle D; o_valid at D+1.
- o_result and o_valid held unchanged under backpressure (i_ready=0) indefinitely.
- No new request accepted until the cycle after the result is taken (o_ready only in IDLE); back-to-back accept earliest at hand-off cycle+1.
- i_rst mid-operation: IDLE next cycle, all outputs to reset values; core shares the same reset.

## Configuration
- DIV_RESULT_CACHE_EN defined: one-entry cache {valid, rs1, rs2, signed, quotient, remainder}, written on every core completion with sign-corrected quotient and remainder. Request with matching rs1, rs2, signedness and valid entry: no core start, result (quotient or remainder per op) with o_valid at T+1. Entry cleared by i_rst; flush never writes it; special cases neither hit-checked against nor stored.
- Not defined: no cache storage; every non-special request runs the core.

## Test plan
- DIV rs1=0xFFFFFFF9 (-7), rs2=2 -> o_result=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 0xFFFFFFFF/0x10 -> 0x0FFFFFFF; REMU -> 0xF.
- DIV 5/0 -> 0xFFFFFFFF, REM 5/0 -> 5, DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0; each o_valid at T+1, o_core_start never asserted.
- Hold i_ready=0 for 10 cycles after o_valid -> o_result and o_valid stable, o_ready=0, new i_valid not accepted.
- i_flush in WAIT, then new DIVU 100/7 accepted; stale i_core_done from aborted run ignored -> o_result=14.
- i_rst asserted in WAIT -> next cycle all outputs at reset values, state IDLE.
- With DIV_RESULT_CACHE_EN: DIV 100/7 (=14) then REM 100/7 -> 2 at T+1, no o_core_start; REMU 100/7 -> core run (signedness mismatch) -> 2.
